// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions, FSM encodings and divisor floor for uart_mmio_fifo
package uart_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_RX_OVR    = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_TX_DROP   = 6;
  localparam int ST_BUSY      = 9;
  localparam int MIN_DIV = 4;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, extra pointer MSB separates full from empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_head  = r_mem[r_rp[AW-1:0]];
  // pointer advance; callers never push into a full FIFO without a same-cycle pop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp + 1'b1;
    end
  end
  // storage write; a full push+pop overwrites the slot being read out this cycle
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: MMIO full-duplex UART with TX/RX FIFOs and programmable divisor; UART_LOOPBACK_EN adds CTRL.LOOPBACK
module uart_mmio_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 8,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_FREQ_HZ / BAUD_RATE);
  logic [1:0]       w_reg;
  logic             w_wr, w_data_wr, w_stat_wr, w_div_wr;
  logic [31:0]      w_div_m, w_status;
  logic [DIV_W-1:0] w_div_new;
  logic [DIV_W-1:0] r_div;
  logic             r_rx_ovr, r_frame_err, r_tx_drop;
  logic             w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_tick, w_tx_line;
  logic [7:0]       w_tx_head;
  tx_state_e        r_tx_st, w_tx_nxt;
  logic [DIV_W-1:0] r_tx_div, r_tx_cnt;
  logic [7:0]       r_tx_sh;
  logic [2:0]       r_tx_bit;
  logic             w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_done, w_ferr_set, w_ovr_set;
  logic             w_rx_in, w_rx_line, w_rx_fall, w_rx_tick, w_rx_mid;
  logic [7:0]       w_rx_head;
  logic [1:0]       r_rx_s;
  logic             r_rx_q;
  rx_state_e        r_rx_st, w_rx_nxt;
  logic [DIV_W-1:0] r_rx_div, r_rx_cnt;
  logic [7:0]       r_rx_sh;
  logic [2:0]       r_rx_bit;
  logic             w_ctrl;
  logic             w_unused;
  assign w_reg     = mem_addr[3:2];
  assign w_wr      = sel & |mem_wmask;
  assign w_data_wr = w_wr & mem_wmask[0] & (w_reg == REG_DATA);
  assign w_stat_wr = w_wr & mem_wmask[0] & (w_reg == REG_STATUS);
  assign w_div_wr  = w_wr & (w_reg == REG_DIV);
  assign w_tx_push = w_data_wr & !w_tx_full;
  assign w_rx_pop  = sel & mem_rstrb & (w_reg == REG_DATA) & !w_rx_empty;
  assign w_rx_push = w_rx_done & (!w_rx_full | w_rx_pop);
  assign w_ovr_set = w_rx_done & w_rx_full & !w_rx_pop;
  assign w_unused  = ^{mem_addr[1:0], w_div_m};
`ifdef UART_LOOPBACK_EN
  logic r_loop;
  // CTRL.LOOPBACK register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_loop <= 1'b0;
    else if (w_wr && mem_wmask[0] && w_reg == REG_CTRL) r_loop <= mem_wdata[0];
  end
  assign w_rx_in = r_loop ? w_tx_line : rxd;
  assign txd     = r_loop | w_tx_line;
  assign w_ctrl  = r_loop;
`else
  assign w_rx_in = rxd;
  assign txd     = w_tx_line;
  assign w_ctrl  = 1'b0;
`endif
  // merge byte lanes into the current divisor, then apply the floor
  always_comb begin
    w_div_m = 32'(r_div);
    for (int i = 0; i < 4; i++) w_div_m[8*i+:8] = mem_wmask[i] ? mem_wdata[8*i+:8] : w_div_m[8*i+:8];
    w_div_new = (w_div_m[DIV_W-1:0] < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : w_div_m[DIV_W-1:0];
  end
  // divisor register and sticky error flags (a same-cycle set beats a W1C clear)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div       <= DIV_RST;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_drop   <= 1'b0;
    end else begin
      if (w_div_wr) r_div <= w_div_new;
      r_rx_ovr    <= w_ovr_set | (r_rx_ovr & !(w_stat_wr & mem_wdata[ST_RX_OVR]));
      r_frame_err <= w_ferr_set | (r_frame_err & !(w_stat_wr & mem_wdata[ST_FRAME_ERR]));
      r_tx_drop   <= (w_data_wr & w_tx_full) | (r_tx_drop & !(w_stat_wr & mem_wdata[ST_TX_DROP]));
    end
  end
  // status word and combinational read mux
  always_comb begin
    w_status = '0;
    w_status[ST_TX_FULL]   = w_tx_full;
    w_status[ST_TX_EMPTY]  = w_tx_empty;
    w_status[ST_RX_EMPTY]  = w_rx_empty;
    w_status[ST_RX_FULL]   = w_rx_full;
    w_status[ST_RX_OVR]    = r_rx_ovr;
    w_status[ST_FRAME_ERR] = r_frame_err;
    w_status[ST_TX_DROP]   = r_tx_drop;
    w_status[ST_BUSY]      = !w_tx_empty | (r_tx_st != TX_IDLE);
    mem_rdata = (w_reg == REG_DATA)   ? {23'b0, !w_rx_empty, w_rx_empty ? 8'h00 : w_rx_head} :
                (w_reg == REG_STATUS) ? w_status :
                (w_reg == REG_DIV)    ? 32'(r_div) : {31'b0, w_ctrl};
  end
  assign irq = !w_rx_empty | r_rx_ovr | r_frame_err | r_tx_drop;
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .i_push(w_tx_push), .i_data(mem_wdata[7:0]), .i_pop(w_tx_pop),
    .o_full(w_tx_full), .o_empty(w_tx_empty), .o_head(w_tx_head)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .i_push(w_rx_push), .i_data(r_rx_sh), .i_pop(w_rx_pop),
    .o_full(w_rx_full), .o_empty(w_rx_empty), .o_head(w_rx_head)
  );
  assign w_tx_tick = r_tx_cnt == r_tx_div - DIV_W'(1);
  // TX line level is decoded from state so an async reset forces it high at once
  always_comb begin
    w_tx_line = (r_tx_st == TX_START) ? 1'b0 : (r_tx_st == TX_DATA) ? r_tx_sh[r_tx_bit] : 1'b1;
  end
  // TX next state; each non-idle state lasts the divisor latched at frame start
  always_comb begin
    w_tx_nxt = r_tx_st;
    w_tx_pop = 1'b0;
    case (r_tx_st)
      TX_IDLE:  if (!w_tx_empty) begin w_tx_pop = 1'b1; w_tx_nxt = TX_START; end
      TX_START: if (w_tx_tick) w_tx_nxt = TX_DATA;
      TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_nxt = TX_STOP;
      TX_STOP:  if (w_tx_tick) w_tx_nxt = TX_IDLE;
      default:  w_tx_nxt = TX_IDLE;
    endcase
  end
  // TX state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_tx_st <= TX_IDLE;
    else r_tx_st <= w_tx_nxt;
  end
  // TX shifter, bit timer and bit index
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_div <= DIV_RST;
      r_tx_cnt <= '0;
      r_tx_sh  <= '0;
      r_tx_bit <= '0;
    end else begin
      if (w_tx_pop) begin
        r_tx_sh  <= w_tx_head;
        r_tx_div <= r_div;
      end
      r_tx_cnt <= (r_tx_st == TX_IDLE || w_tx_tick) ? '0 : r_tx_cnt + DIV_W'(1);
      r_tx_bit <= (r_tx_st != TX_DATA) ? 3'd0 : w_tx_tick ? r_tx_bit + 3'd1 : r_tx_bit;
    end
  end
  // rxd synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_s <= 2'b11;
      r_rx_q <= 1'b1;
    end else begin
      r_rx_s <= {r_rx_s[0], w_rx_in};
      r_rx_q <= r_rx_s[1];
    end
  end
  assign w_rx_line = r_rx_s[1];
  assign w_rx_fall = r_rx_q & !w_rx_line;
  assign w_rx_tick = r_rx_cnt == r_rx_div - DIV_W'(1);
  assign w_rx_mid  = r_rx_cnt == (r_rx_div >> 1) - DIV_W'(1);
  // RX next state: start bit checked at half period, data/stop one full period apart
  always_comb begin
    w_rx_nxt   = r_rx_st;
    w_rx_done  = 1'b0;
    w_ferr_set = 1'b0;
    case (r_rx_st)
      RX_IDLE:  if (w_rx_fall) w_rx_nxt = RX_START;
      RX_START: if (w_rx_mid) w_rx_nxt = w_rx_line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP:  if (w_rx_tick) begin
        w_rx_nxt   = w_rx_line ? RX_IDLE : RX_WAIT;
        w_rx_done  = w_rx_line;
        w_ferr_set = !w_rx_line;
      end
      RX_WAIT:  if (w_rx_line) w_rx_nxt = RX_IDLE;
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end
  // RX state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rx_st <= RX_IDLE;
    else r_rx_st <= w_rx_nxt;
  end
  // RX shifter, bit timer and bit index
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_div <= DIV_RST;
      r_rx_cnt <= '0;
      r_rx_sh  <= '0;
      r_rx_bit <= '0;
    end else begin
      if (r_rx_st == RX_IDLE && w_rx_fall) r_rx_div <= r_div;
      r_rx_cnt <= (r_rx_st == RX_IDLE || w_rx_nxt != r_rx_st || w_rx_tick) ? '0 : r_rx_cnt + DIV_W'(1);
      if (r_rx_st == RX_DATA && w_rx_tick) begin
        r_rx_sh  <= {w_rx_line, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// tb_uart_mmio_fifo: scoreboard bench for uart_mmio_fifo; UART_LOOPBACK_EN enables the loopback section
module tb_uart_mmio_fifo;
  import uart_pkg::*;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        rxd = 1'b1;
  logic        txd;
  logic        irq;
  int n_vec = 0;
  int n_bad = 0;
  int div = 1250;
  bit mon_off = 1'b0;
  typedef struct {logic [32:0] v; logic [32:0] m; string n;} exp_t;
  exp_t       rd_q[$];
  logic [7:0] tx_q[$];

  uart_mmio_fifo dut (
    .clk(clk), .resetn(resetn), .sel(sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  // read monitor: compares {irq, rdata} under mask whenever a read strobe is presented
  always @(negedge clk) begin
    if (sel && mem_rstrb) begin
      exp_t e;
      n_vec++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read got=%h", {irq, mem_rdata});
      end else begin
        e = rd_q.pop_front();
        if ((({irq, mem_rdata} ^ e.v) & e.m) != 0) begin
          n_bad++;
          $display("FAIL %s got=%h exp=%h mask=%h", e.n, {irq, mem_rdata}, e.v, e.m);
        end
      end
    end
  end

  // TX monitor: checks every cycle of each frame against the expected 8N1 waveform
  initial forever begin
    @(negedge clk);
    if (txd === 1'b0) begin
      int d;
      int errs;
      bit skip;
      logic [9:0] fr;
      logic [7:0] got;
      logic [7:0] ex;
      d = div;
      errs = 0;
      got = '0;
      skip = mon_off;
      ex = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      fr = {1'b1, ex, 1'b0};
      for (int s = 0; s < 10 * d; s++) begin
        if (s > 0) @(negedge clk);
        if (txd !== fr[s/d]) errs++;
        if (s % d == d / 2 && s / d >= 1 && s / d <= 8) got[s/d-1] = txd;
      end
      if (!skip) begin
        n_vec++;
        if (tx_q.size() == 0) begin
          n_bad++;
          $display("FAIL tx_unexpected_frame got=%h", got);
        end else begin
          void'(tx_q.pop_front());
          if (errs != 0) begin
            n_bad++;
            $display("FAIL tx_frame got=%h exp=%h bad_cycles=%0d", got, ex, errs);
          end
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic [1:0] r, input logic [31:0] d, input logic [3:0] m, input logic re);
    sel = 1'b1;
    mem_addr = {r, 2'b00};
    mem_wdata = d;
    mem_wmask = we ? m : 4'h0;
    mem_rstrb = re;
    wait_cyc(1);
  endtask

  task automatic idle();
    sel = 1'b0;
    mem_wmask = 4'h0;
    mem_rstrb = 1'b0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] m);
    bus(1'b1, r, d, m, 1'b0);
    idle();
  endtask

  task automatic rd(input logic [1:0] r, input logic [31:0] v, input logic [31:0] m, input logic iv, input logic im, input string n);
    rd_q.push_back('{v: {iv, v}, m: {im, m}, n: n});
    bus(1'b0, r, 32'h0, 4'h0, 1'b1);
    idle();
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = f[k];
      wait_cyc(div);
    end
    rxd = 1'b1;
    wait_cyc(div);
  endtask

  initial begin
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(1);
    rd(REG_STATUS, 32'h006, '1, 1'b0, 1'b1, "rst_status");
    rd(REG_DIV, 32'd1250, '1, 1'b0, 1'b1, "rst_div");
    rd(REG_CTRL, 32'h0, '1, 1'b0, 1'b1, "rst_ctrl");
    rd(REG_DATA, 32'h0, '1, 1'b0, 1'b1, "rst_data");
    chk("rst_txd", 32'(txd), 32'h1);
    wr(REG_DIV, 32'h2, 4'hF);
    rd(REG_DIV, 32'h4, '1, 1'b0, 1'b0, "div_clamp");
    wr(REG_DIV, 32'h0000_0100, 4'b0010);
    rd(REG_DIV, 32'h104, '1, 1'b0, 1'b0, "div_bytemask");
    wr(REG_DIV, 32'h4, 4'hF);
    div = 4;
    tx_q.push_back(8'h55);
    wr(REG_DATA, 32'h55, 4'hF);
    wait_cyc(10);
    rd(REG_STATUS, 32'h200, 32'h200, 1'b0, 1'b0, "busy_in_frame");
    wait_cyc(40);
    rd(REG_STATUS, 32'h006, '1, 1'b0, 1'b1, "busy_after_frame");
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) tx_q.push_back(8'(i));
      bus(1'b1, REG_DATA, 32'(i), 4'hF, 1'b0);
    end
    idle();
    rd(REG_STATUS, 32'h241, 32'h241, 1'b1, 1'b1, "tx_drop_set");
    wr(REG_STATUS, 32'h40, 4'hF);
    rd(REG_STATUS, 32'h0, 32'h40, 1'b0, 1'b1, "tx_drop_clr");
    wait_cyc(450);
    chk("tx_all_frames", 32'(tx_q.size()), 32'h0);
    wr(REG_DIV, 32'h8, 4'hF);
    div = 8;
    send_rx(8'hA3, 1'b1);
    wait_cyc(4);
    rd(REG_STATUS, 32'h002, '1, 1'b1, 1'b1, "rx_nonempty");
    rd(REG_DATA, 32'h1A3, '1, 1'b1, 1'b1, "rx_a3");
    rd(REG_DATA, 32'h000, '1, 1'b0, 1'b1, "rx_empty_read");
    for (int b = 1; b <= 9; b++) send_rx(8'(b), 1'b1);
    rd(REG_STATUS, 32'h01A, '1, 1'b1, 1'b1, "rx_ovr_full");
    for (int b = 1; b <= 8; b++) rd(REG_DATA, 32'h100 | 32'(b), '1, 1'b1, 1'b1, "rx_order");
    wr(REG_STATUS, 32'h10, 4'hF);
    rd(REG_STATUS, 32'h006, '1, 1'b0, 1'b1, "ovr_clr");
    send_rx(8'h5A, 1'b0);
    rd(REG_STATUS, 32'h026, '1, 1'b1, 1'b1, "frame_err");
    wr(REG_STATUS, 32'h20, 4'hF);
    rd(REG_STATUS, 32'h006, '1, 1'b0, 1'b1, "ferr_clr");
    rxd = 1'b0;
    wait_cyc(1);
    rxd = 1'b1;
    wait_cyc(40);
    rd(REG_STATUS, 32'h006, '1, 1'b0, 1'b1, "glitch_no_frame");
`ifdef UART_LOOPBACK_EN
    begin
      int lows;
      lows = 0;
      wr(REG_CTRL, 32'h1, 4'hF);
      rd(REG_CTRL, 32'h1, '1, 1'b0, 1'b1, "ctrl_loop_rd");
      wr(REG_DATA, 32'h3C, 4'hF);
      for (int c = 0; c < 120; c++) begin
        @(negedge clk);
        if (txd !== 1'b1) lows++;
      end
      wait_cyc(1);
      chk("lb_txd_held", 32'(lows), 32'h0);
      rd(REG_DATA, 32'h13C, '1, 1'b1, 1'b1, "lb_rx_3c");
      wr(REG_CTRL, 32'h0, 4'hF);
    end
`else
    wr(REG_CTRL, 32'h1, 4'hF);
    rd(REG_CTRL, 32'h0, '1, 1'b0, 1'b1, "ctrl_absent");
`endif
    mon_off = 1'b1;
    wr(REG_DATA, 32'h00, 4'hF);
    wait_cyc(24);
    chk("pre_rst_txd_low", 32'(txd), 32'h0);
    resetn = 1'b0;
    #1;
    chk("rst_async_txd", 32'(txd), 32'h1);
    wait_cyc(2);
    resetn = 1'b1;
    div = 1250;
    wait_cyc(1);
    rd(REG_STATUS, 32'h006, '1, 1'b0, 1'b1, "rst_mid_status");
    rd(REG_DIV, 32'd1250, '1, 1'b0, 1'b1, "rst_mid_div");
    wait_cyc(2);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
